// File: rtl/vga_sync_rx.sv
// vga_sync_rx: locks onto an incoming VGA stream, measures line/frame lengths and recovers pixel x/y.
// Define VGA_RX_BAR_CHECK_EN to build the colour-bar checker that drives bar_err and gates frame_ok.
`timescale 1ns/1ps
module vga_sync_rx #(
    parameter int H_TOTAL = 800,
    parameter int H_PULSE = 96,
    parameter int H_BP    = 48,
    parameter int H_VIZ   = 640,
    parameter int V_TOTAL = 525,
    parameter int V_PULSE = 2,
    parameter int V_BP    = 33,
    parameter int V_VIZ   = 480
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hs_in,
    input  logic        vs_in,
    input  logic [2:0]  r_in,
    input  logic [2:0]  g_in,
    input  logic [1:0]  b_in,
    output logic        locked,
    output logic        px_valid,
    output logic [9:0]  px_x,
    output logic [9:0]  px_y,
    output logic [2:0]  px_r,
    output logic [2:0]  px_g,
    output logic [1:0]  px_b,
    output logic [10:0] h_len,
    output logic [10:0] v_len,
    output logic [7:0]  err_cnt,
    output logic [15:0] bar_err,
    output logic        frame_ok
);
    typedef enum logic [1:0] {SEARCH = 2'd0, TRACK = 2'd1, LOCKED = 2'd2} state_t;

    localparam logic [10:0] H_TOT_L   = 11'(H_TOTAL);
    localparam logic [10:0] V_TOT_L   = 11'(V_TOTAL);
    localparam logic [10:0] H_START_L = 11'(H_PULSE + H_BP);
    localparam logic [10:0] H_END_L   = 11'(H_PULSE + H_BP + H_VIZ);
    localparam logic [10:0] V_START_L = 11'(V_PULSE + V_BP);
    localparam logic [10:0] V_END_L   = 11'(V_PULSE + V_BP + V_VIZ);
    localparam logic [10:0] CNT_MAX   = 11'h7FF;

    logic [9:0]  s1_reg, s2_reg;   // {hs, vs, r, g, b}
    logic [7:0]  rgb3_reg;
    logic        hs_prev_reg, vs_prev_reg;
    logic [10:0] h_cnt_reg, v_cnt_reg, h_len_reg, v_len_reg;
    logic        vs_pend_reg;
    state_t      state_reg, state_next;
    logic [1:0]  good_reg, good_next;
    logic        line_bad_reg, line_bad_next, line_bad_now;
    logic [7:0]  err_cnt_reg, err_next;
    logic        clean_end;
    logic        px_valid_reg;
    logic [9:0]  px_x_reg, px_y_reg;
    logic [7:0]  px_rgb_reg;
    logic        frame_ok_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_reg      <= '0;
            s2_reg      <= '0;
            rgb3_reg    <= '0;
            hs_prev_reg <= 1'b0;
            vs_prev_reg <= 1'b0;
        end else begin
            s1_reg      <= {hs_in, vs_in, r_in, g_in, b_in};
            s2_reg      <= s1_reg;
            rgb3_reg    <= s2_reg[7:0];
            hs_prev_reg <= s2_reg[9];
            vs_prev_reg <= s2_reg[8];
        end
    end

    logic        hs_fall, vs_fall, pend_eff, frame_end, h_ok, v_ok, h_sat;
    logic [10:0] meas_h, meas_v;
    assign hs_fall   = hs_prev_reg & ~s2_reg[9];
    assign vs_fall   = vs_prev_reg & ~s2_reg[8];
    // A VS edge coincident with the HS edge counts as already pending.
    assign pend_eff  = vs_pend_reg | vs_fall;
    assign frame_end = hs_fall & pend_eff;
    assign meas_h    = h_cnt_reg + 11'd1;
    assign meas_v    = v_cnt_reg + 11'd1;
    assign h_ok      = (meas_h == H_TOT_L);
    assign v_ok      = (meas_v == V_TOT_L);
    assign h_sat     = (h_cnt_reg == CNT_MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_cnt_reg   <= '0;
            v_cnt_reg   <= '0;
            h_len_reg   <= '0;
            v_len_reg   <= '0;
            vs_pend_reg <= 1'b0;
        end else if (hs_fall) begin
            h_len_reg <= meas_h;
            h_cnt_reg <= '0;
            if (pend_eff) begin
                v_len_reg   <= meas_v;
                v_cnt_reg   <= '0;
                vs_pend_reg <= 1'b0;
            end else if (v_cnt_reg != CNT_MAX) begin
                v_cnt_reg <= meas_v;
            end
        end else begin
            if (!h_sat) h_cnt_reg <= meas_h;
            if (vs_fall) vs_pend_reg <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= SEARCH;
            good_reg     <= '0;
            line_bad_reg <= 1'b0;
            err_cnt_reg  <= '0;
        end else begin
            state_reg    <= state_next;
            good_reg     <= good_next;
            line_bad_reg <= line_bad_next;
            err_cnt_reg  <= err_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        good_next     = good_reg;
        line_bad_next = line_bad_reg;
        err_next      = err_cnt_reg;
        clean_end     = 1'b0;
        line_bad_now  = line_bad_reg | (hs_fall & ~h_ok);
        case (state_reg)
            SEARCH: begin
                if (frame_end) begin
                    state_next    = TRACK;
                    good_next     = 2'd0;
                    line_bad_next = 1'b0;
                end
            end
            TRACK: begin
                if (h_sat) begin
                    state_next = SEARCH;
                end else if (frame_end) begin
                    line_bad_next = 1'b0;
                    if (v_ok && !line_bad_now) begin
                        good_next = good_reg + 2'd1;
                        if (good_reg == 2'd1) state_next = LOCKED;
                    end else begin
                        good_next = 2'd0;
                    end
                end else begin
                    line_bad_next = line_bad_now;
                end
            end
            LOCKED: begin
                if (h_sat || (hs_fall && !h_ok) || (frame_end && !v_ok)) begin
                    state_next = SEARCH;
                    if (err_cnt_reg != 8'hFF) err_next = err_cnt_reg + 8'd1;
                end else if (frame_end) begin
                    clean_end = 1'b1;
                end
            end
            default: state_next = SEARCH;
        endcase
    end

    // Counters and rgb3_reg both describe the same sample, so one more stage aligns px_*.
    logic        in_win;
    logic [10:0] x_full, y_full;
    assign x_full = h_cnt_reg - H_START_L;
    assign y_full = v_cnt_reg - V_START_L;
    assign in_win = (state_reg == LOCKED)
                  && (h_cnt_reg >= H_START_L) && (h_cnt_reg < H_END_L)
                  && (v_cnt_reg >= V_START_L) && (v_cnt_reg < V_END_L);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            px_valid_reg <= 1'b0;
            px_x_reg     <= '0;
            px_y_reg     <= '0;
            px_rgb_reg   <= '0;
        end else begin
            px_valid_reg <= in_win;
            px_x_reg     <= in_win ? x_full[9:0] : 10'd0;
            px_y_reg     <= in_win ? y_full[9:0] : 10'd0;
            px_rgb_reg   <= in_win ? rgb3_reg : 8'd0;
        end
    end

`ifdef VGA_RX_BAR_CHECK_EN
    logic [2:0]  bar_idx;
    logic [6:0]  bar_col;
    logic [7:0]  bar_exp;
    logic        bar_chk, mismatch, frame_bad_reg;
    logic [15:0] bar_err_reg;
    assign bar_idx  = 3'(px_x_reg / 10'd80);
    assign bar_col  = 7'(px_x_reg % 10'd80);
    // Bar order white..black maps to r=~idx[1], g=~idx[2], b=~idx[0].
    assign bar_exp  = {{3{~bar_idx[1]}}, {3{~bar_idx[2]}}, {2{~bar_idx[0]}}};
    assign bar_chk  = (bar_col >= 7'd2) && (bar_col <= 7'd77);
    assign mismatch = px_valid_reg & bar_chk & (px_rgb_reg != bar_exp);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bar_err_reg   <= '0;
            frame_bad_reg <= 1'b0;
            frame_ok_reg  <= 1'b0;
        end else begin
            if (mismatch && bar_err_reg != 16'hFFFF) bar_err_reg <= bar_err_reg + 16'd1;
            frame_bad_reg <= frame_end ? 1'b0 : (frame_bad_reg | mismatch);
            frame_ok_reg  <= clean_end & ~(frame_bad_reg | mismatch);
        end
    end
    assign bar_err = bar_err_reg;
`else
    always_ff @(posedge clk or posedge rst) begin
        if (rst) frame_ok_reg <= 1'b0;
        else     frame_ok_reg <= clean_end;
    end
    assign bar_err = 16'd0;
`endif

    assign locked   = (state_reg == LOCKED);
    assign px_valid = px_valid_reg;
    assign px_x     = px_x_reg;
    assign px_y     = px_y_reg;
    assign px_r     = px_rgb_reg[7:5];
    assign px_g     = px_rgb_reg[4:2];
    assign px_b     = px_rgb_reg[1:0];
    assign h_len    = h_len_reg;
    assign v_len    = v_len_reg;
    assign err_cnt  = err_cnt_reg;
    assign frame_ok = frame_ok_reg;
endmodule
